// File: rtl/vga_pkg.sv
// Shared constants and types for the 1080p60 line-fetch scheduler: timing totals,
// FSM state encoding and small counter helpers.
package vga_pkg;

    localparam int VGA_H_ACT       = 1920;
    localparam int VGA_H_FP        = 88;
    localparam int VGA_H_SYNC      = 44;
    localparam int VGA_H_BP        = 148;
    localparam int VGA_H_TOTAL     = VGA_H_ACT + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_ACT       = 1080;
    localparam int VGA_V_FP        = 4;
    localparam int VGA_V_SYNC      = 5;
    localparam int VGA_V_BP        = 36;
    localparam int VGA_V_TOTAL     = VGA_V_ACT + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_LINE_STRIDE = 7680;

    localparam int CNT_W = 11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        REQ   = 3'd2,
        WAIT  = 3'd3,
        FLUSH = 3'd4
    } fetch_state_e;

    // Lines requested but not yet consumed; req never trails cons, so plain modulo subtraction is exact.
    function automatic logic [CNT_W-1:0] lines_ahead(input logic [CNT_W-1:0] req_line,
                                                     input logic [CNT_W-1:0] cons_line);
        return req_line - cons_line;
    endfunction

endpackage

// File: rtl/vga_line_fetch_ctrl_if.sv
// Request/response bus between the line-fetch scheduler and the memory line reader.
interface vga_line_fetch_ctrl_if #(
    parameter int ADDR_W = 32
) ();

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic [11:0]       req_len;
    logic              req_ready;
    logic              line_done;

    modport master (
        output req_valid,
        output req_addr,
        output req_len,
        input  req_ready,
        input  line_done
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_len,
        output req_ready,
        output line_done
    );

endinterface

// File: rtl/vga_edge_det.sv
// Single-edge detector: registers the input once and flags either its rising or
// its falling transition (selected by RISING) in the cycle the new level is seen.
module vga_edge_det #(
    parameter bit RISING = 1'b1
) (
    input  logic vga_clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic pulse_o
);

    logic sig_d;
    logic sig_q;

    // Next value of the delayed copy is simply the current input level.
    always_comb begin
        sig_d = sig_i;
    end

    // Delayed copy of the input for edge comparison.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    // Edge decode against the delayed copy.
    always_comb begin
        if (RISING) begin
            pulse_o = sig_i & ~sig_q;
        end else begin
            pulse_o = ~sig_i & sig_q;
        end
    end

endmodule

// File: rtl/vga_line_fetch_ctrl.sv
// Frame-buffer line fetch scheduler: keeps up to PREFETCH_LINES lines requested ahead
// of the display, one request in flight at a time, and reports line underflow.
module vga_line_fetch_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACT          = VGA_H_ACT,
    parameter int V_ACT          = VGA_V_ACT,
    parameter int ADDR_W         = 32,
    parameter int LINE_STRIDE    = VGA_LINE_STRIDE,
    parameter int PREFETCH_LINES = 2
) (
    input  logic                    vga_clk,
    input  logic                    rst_n,
    input  logic [ADDR_W-1:0]       frame_base,
    input  logic                    v_sync,
    input  logic                    pixel_de,
    vga_line_fetch_ctrl_if.master   bus,
    output logic                    frame_start,
    output logic                    underflow,
    output logic                    busy
);

    localparam logic [CNT_W-1:0]  V_LIM   = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0]  PF_LIM  = CNT_W'(PREFETCH_LINES);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(LINE_STRIDE);
    localparam logic [11:0]       LEN     = 12'(H_ACT);

    logic vs_rise_s;
    logic de_rise_s;
    logic de_fall_s;
    logic accept_s;

    fetch_state_e      state_q,       state_d;
    logic [CNT_W-1:0]  req_line_q,    req_line_d;
    logic [CNT_W-1:0]  dlv_line_q,    dlv_line_d;
    logic [CNT_W-1:0]  cons_line_q,   cons_line_d;
    logic [ADDR_W-1:0] req_addr_q,    req_addr_d;
    logic [ADDR_W-1:0] shadow_base_q, shadow_base_d;
    logic              req_valid_q,   req_valid_d;
    logic [11:0]       req_len_q,     req_len_d;
    logic              frame_start_q, frame_start_d;
    logic              underflow_q,   underflow_d;
    logic              busy_q,        busy_d;

    vga_edge_det #(.RISING(1'b1)) u_vs_rise (
        .vga_clk (vga_clk),
        .rst_n   (rst_n),
        .sig_i   (v_sync),
        .pulse_o (vs_rise_s)
    );

    vga_edge_det #(.RISING(1'b1)) u_de_rise (
        .vga_clk (vga_clk),
        .rst_n   (rst_n),
        .sig_i   (pixel_de),
        .pulse_o (de_rise_s)
    );

    vga_edge_det #(.RISING(1'b0)) u_de_fall (
        .vga_clk (vga_clk),
        .rst_n   (rst_n),
        .sig_i   (pixel_de),
        .pulse_o (de_fall_s)
    );

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d       = state_q;
        req_line_d    = req_line_q;
        dlv_line_d    = dlv_line_q;
        cons_line_d   = cons_line_q;
        req_addr_d    = req_addr_q;
        shadow_base_d = shadow_base_q;
        accept_s      = (state_q == REQ) && req_valid_q && bus.req_ready;

        case (state_q)
            IDLE: begin
                if (vs_rise_s) begin
                    state_d = ARM;
                end else begin
                    state_d = IDLE;
                end
            end
            ARM: begin
                shadow_base_d = frame_base;
                req_addr_d    = frame_base;
                req_line_d    = '0;
                dlv_line_d    = '0;
                if (vs_rise_s) begin
                    state_d = ARM;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // A handshake landing with vs_rise still leaves a line in flight: drain it first.
                if (accept_s) begin
                    req_line_d = req_line_q + CNT_ONE;
                    state_d    = vs_rise_s ? FLUSH : WAIT;
                end else if (vs_rise_s) begin
                    state_d = ARM;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (bus.line_done) begin
                    dlv_line_d = dlv_line_q + CNT_ONE;
                    req_addr_d = req_addr_q + STRIDE;
                    state_d    = vs_rise_s ? ARM : REQ;
                end else if (vs_rise_s) begin
                    state_d = FLUSH;
                end else begin
                    state_d = WAIT;
                end
            end
            FLUSH: begin
                if (bus.line_done) begin
                    state_d = ARM;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Consumption saturates at the request count so req_line >= cons_line always holds.
        if (state_q == ARM) begin
            cons_line_d = '0;
        end else if (de_fall_s && (cons_line_q < req_line_q)) begin
            cons_line_d = cons_line_q + CNT_ONE;
        end else begin
            cons_line_d = cons_line_q;
        end

        req_valid_d   = (state_d == REQ)
                      && (lines_ahead(req_line_d, cons_line_d) < PF_LIM)
                      && (req_line_d < V_LIM);
        req_len_d     = LEN;
        frame_start_d = vs_rise_s;
        underflow_d   = de_rise_s && (dlv_line_q == cons_line_q);
        busy_d        = (state_d == WAIT) || (state_d == FLUSH);
    end

    // State, counters and output registers.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_line_q    <= '0;
            dlv_line_q    <= '0;
            cons_line_q   <= '0;
            req_addr_q    <= '0;
            shadow_base_q <= '0;
            req_valid_q   <= 1'b0;
            req_len_q     <= 12'd0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_line_q    <= req_line_d;
            dlv_line_q    <= dlv_line_d;
            cons_line_q   <= cons_line_d;
            req_addr_q    <= req_addr_d;
            shadow_base_q <= shadow_base_d;
            req_valid_q   <= req_valid_d;
            req_len_q     <= req_len_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.req_valid = req_valid_q;
    assign bus.req_addr  = req_addr_q;
    assign bus.req_len   = req_len_q;
    assign frame_start   = frame_start_q;
    assign underflow     = underflow_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_vga_line_fetch_ctrl.sv
// Self-checking bench for vga_line_fetch_ctrl with a small-frame configuration
// and a behavioural line reader that answers accepted requests with line_done.
module tb_vga_line_fetch_ctrl;

    localparam int ADDR_W = 32;
    localparam int HA     = 8;
    localparam int VA     = 4;
    localparam int STR    = 32;
    localparam int PF     = 2;

    logic              vga_clk = 1'b0;
    logic              rst_n   = 1'b0;
    logic [ADDR_W-1:0] frame_base = 32'h0;
    logic              v_sync   = 1'b0;
    logic              pixel_de = 1'b0;
    logic              frame_start;
    logic              underflow;
    logic              busy;

    vga_line_fetch_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    vga_line_fetch_ctrl #(
        .H_ACT(HA), .V_ACT(VA), .ADDR_W(ADDR_W), .LINE_STRIDE(STR), .PREFETCH_LINES(PF)
    ) dut (
        .vga_clk     (vga_clk),
        .rst_n       (rst_n),
        .frame_base  (frame_base),
        .v_sync      (v_sync),
        .pixel_de    (pixel_de),
        .bus         (bus),
        .frame_start (frame_start),
        .underflow   (underflow),
        .busy        (busy)
    );

    always #5 vga_clk = ~vga_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;
    int uf_cnt   = 0;
    int fs_cnt   = 0;
    int ld_delay = 1;
    bit ld_hold  = 1'b0;
    logic [ADDR_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge vga_clk);
            #1;
        end
    endtask

    // Reader model and monitor: score accepted addresses, answer with line_done after ld_delay.
    initial begin
        int  ld_cnt;
        bit  ld_pend;
        logic [ADDR_W-1:0] exp_addr;
        ld_cnt        = 0;
        ld_pend       = 1'b0;
        bus.line_done = 1'b0;
        forever begin
            @(negedge vga_clk);
            if (!rst_n) begin
                ld_pend = 1'b0;
            end else begin
                if (bus.req_valid && bus.req_ready) begin
                    acc_cnt++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_req: got addr 0x%0h, expected no request", bus.req_addr);
                    end else begin
                        exp_addr = exp_q.pop_front();
                        check("req_addr", bus.req_addr, exp_addr);
                    end
                    ld_cnt  = ld_delay;
                    ld_pend = 1'b1;
                end
                if (underflow) uf_cnt++;
                if (frame_start) fs_cnt++;
            end
            @(posedge vga_clk);
            #1;
            bus.line_done = 1'b0;
            if (ld_pend && !ld_hold && rst_n) begin
                if (ld_cnt <= 1) begin
                    bus.line_done = 1'b1;
                    ld_pend = 1'b0;
                end else begin
                    ld_cnt--;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n         = 1'b0;
        v_sync        = 1'b0;
        pixel_de      = 1'b0;
        bus.req_ready = 1'b0;
        ld_hold       = 1'b0;
        frame_base    = 32'h0;
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic vsync_pulse(input logic [ADDR_W-1:0] base);
        frame_base = base;
        v_sync     = 1'b1;
        tick(2);
        v_sync     = 1'b0;
        tick(1);
    endtask

    task automatic de_line(input int blank);
        pixel_de = 1'b1;
        tick(HA);
        pixel_de = 1'b0;
        tick(blank);
    endtask

    task automatic wait_acc(input int target, input int budget);
        int n = 0;
        while (acc_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        check("acc_reached", 32'(acc_cnt), 32'(target));
    endtask

    typedef struct {
        logic [31:0] base;
        int          ld_delay;
        int          pre_gap;
        int          exp_pre;
        int          exp_req;
        int          exp_uf;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int a0;
        int u0;
        int f0;

        vecs[0] = '{base: 32'h0000_1000, ld_delay: 3, pre_gap: 30, exp_pre: 2, exp_req: 4, exp_uf: 0};
        vecs[1] = '{base: 32'h0000_4000, ld_delay: 1, pre_gap: 10, exp_pre: 2, exp_req: 4, exp_uf: 0};
        vecs[2] = '{base: 32'hFFFF_FFC0, ld_delay: 5, pre_gap: 20, exp_pre: 2, exp_req: 4, exp_uf: 0};

        // Reset state, sampled while rst_n is low.
        bus.req_ready = 1'b0;
        tick(2);
        check("rst_req_valid",   32'(bus.req_valid), 32'd0);
        check("rst_req_addr",    bus.req_addr,       32'd0);
        check("rst_req_len",     32'(bus.req_len),   32'd0);
        check("rst_frame_start", 32'(frame_start),   32'd0);
        check("rst_underflow",   32'(underflow),     32'd0);
        check("rst_busy",        32'(busy),          32'd0);
        rst_n = 1'b1;
        tick(2);
        check("req_len", 32'(bus.req_len), 32'(HA));

        // Table-driven full frames.
        for (int i = 0; i < 3; i++) begin
            do_reset();
            ld_delay      = vecs[i].ld_delay;
            bus.req_ready = 1'b1;
            a0 = acc_cnt; u0 = uf_cnt; f0 = fs_cnt;
            for (int k = 0; k < vecs[i].exp_req; k++) begin
                exp_q.push_back(vecs[i].base + 32'(k * STR));
            end
            vsync_pulse(vecs[i].base);
            tick(vecs[i].pre_gap);
            check("pre_de_reqs", 32'(acc_cnt - a0), 32'(vecs[i].exp_pre));
            for (int l = 0; l < VA; l++) de_line(4);
            tick(20);
            check("frame_reqs",   32'(acc_cnt - a0),   32'(vecs[i].exp_req));
            check("frame_uf",     32'(uf_cnt - u0),    32'(vecs[i].exp_uf));
            check("frame_fs",     32'(fs_cnt - f0),    32'd1);
            check("frame_idle_v", 32'(bus.req_valid),  32'd0);
            check("frame_busy",   32'(busy),           32'd0);
            check("frame_q_left", 32'(exp_q.size()),   32'd0);
        end

        // Ready stall: request must hold valid and address until the first ready cycle.
        do_reset();
        ld_hold = 1'b1;
        a0 = acc_cnt;
        exp_q.push_back(32'h1000);
        vsync_pulse(32'h1000);
        for (int c = 0; c < 5; c++) begin
            check("stall_valid", 32'(bus.req_valid), 32'd1);
            check("stall_addr",  bus.req_addr,       32'h1000);
            tick(1);
        end
        check("stall_no_acc", 32'(acc_cnt - a0), 32'd0);
        bus.req_ready = 1'b1;
        tick(1);
        check("stall_acc",       32'(acc_cnt - a0),  32'd1);
        check("stall_wait_v",    32'(bus.req_valid), 32'd0);
        check("stall_wait_busy", 32'(busy),          32'd1);

        // Prefetch limit without display, then one more request per consumed line.
        do_reset();
        ld_delay      = 1;
        bus.req_ready = 1'b1;
        a0 = acc_cnt;
        exp_q.push_back(32'h1000);
        exp_q.push_back(32'h1020);
        vsync_pulse(32'h1000);
        tick(20);
        check("pf_reqs",  32'(acc_cnt - a0),  32'd2);
        check("pf_valid", 32'(bus.req_valid), 32'd0);
        check("pf_busy",  32'(busy),          32'd0);
        exp_q.push_back(32'h1040);
        de_line(1);
        wait_acc(a0 + 3, 10);
        tick(10);
        check("pf_reqs_after", 32'(acc_cnt - a0), 32'd3);

        // Underflow: line 0 delivered late, subsequent lines on time.
        do_reset();
        ld_delay      = 1;
        ld_hold       = 1'b1;
        bus.req_ready = 1'b1;
        a0 = acc_cnt; u0 = uf_cnt;
        exp_q.push_back(32'h1000);
        vsync_pulse(32'h1000);
        tick(3);
        check("uf_first_acc", 32'(acc_cnt - a0), 32'd1);
        check("uf_busy",      32'(busy),         32'd1);
        pixel_de = 1'b1;
        tick(2);
        check("uf_pulse", 32'(uf_cnt - u0), 32'd1);
        tick(HA - 2);
        pixel_de = 1'b0;
        tick(2);
        exp_q.push_back(32'h1020);
        exp_q.push_back(32'h1040);
        exp_q.push_back(32'h1060);
        ld_hold = 1'b0;
        tick(8);
        for (int l = 1; l < VA; l++) de_line(8);
        tick(20);
        check("uf_once",  32'(uf_cnt - u0),   32'd1);
        check("uf_reqs",  32'(acc_cnt - a0),  32'd4);
        check("uf_q_left", 32'(exp_q.size()), 32'd0);

        // New frame while a line is in flight: flush, then restart at the new base.
        do_reset();
        ld_delay      = 1;
        ld_hold       = 1'b1;
        bus.req_ready = 1'b1;
        a0 = acc_cnt; f0 = fs_cnt;
        exp_q.push_back(32'h1000);
        vsync_pulse(32'h1000);
        tick(3);
        check("fl_in_wait", 32'(busy), 32'd1);
        vsync_pulse(32'h8000);
        for (int c = 0; c < 4; c++) begin
            check("fl_busy",  32'(busy),          32'd1);
            check("fl_valid", 32'(bus.req_valid), 32'd0);
            tick(1);
        end
        check("fl_fs",   32'(fs_cnt - f0),  32'd2);
        check("fl_acc",  32'(acc_cnt - a0), 32'd1);
        exp_q.push_back(32'h8000);
        exp_q.push_back(32'h8020);
        ld_hold = 1'b0;
        wait_acc(a0 + 3, 20);
        tick(10);
        check("fl_q_left", 32'(exp_q.size()), 32'd0);

        // Reset asserted while a request is pending.
        do_reset();
        a0 = acc_cnt;
        vsync_pulse(32'h1000);
        check("rr_valid_before", 32'(bus.req_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rr_valid_now", 32'(bus.req_valid), 32'd0);
        check("rr_busy_now",  32'(busy),          32'd0);
        tick(1);
        rst_n         = 1'b1;
        bus.req_ready = 1'b1;
        ld_delay      = 1;
        tick(10);
        check("rr_no_acc",   32'(acc_cnt - a0),  32'd0);
        check("rr_valid_lo", 32'(bus.req_valid), 32'd0);
        exp_q.push_back(32'h2000);
        exp_q.push_back(32'h2020);
        vsync_pulse(32'h2000);
        wait_acc(a0 + 2, 20);
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_line_fetch_ctrl.md
Name: vga_line_fetch_ctrl

Overview:
- Schedules frame-buffer line fetches for the 1080p60 video timing generator. It watches the timing generator's v_sync and pixel_de outputs.
- Issues one read request per active line to the memory line reader (DMA/AXI master), keeping up to PREFETCH_LINES lines ahead of the display.
- Latches a new frame base address once per frame and flags line underflow to the control/status logic.

Parameters:
H_ACT, 1920, active pixels per line; value driven on req_len
V_ACT, 1080, active lines per frame; requests issued per frame
ADDR_W, 32, address width
LINE_STRIDE, 7680, bytes between consecutive line start addresses
PREFETCH_LINES, 2, max lines requested but not yet consumed (1..4)

Ports:
vga_clk  in  1  pixel clock
rst_n  in  1  reset; asynchronous, active-low
frame_base  in  ADDR_W  next-frame base address; sampled at frame start
v_sync  in  1  vertical sync from timing generator, active high
pixel_de  in  1  active-video enable from timing generator
req_valid  out  1  line read request valid
req_addr  out  ADDR_W  line start address
req_len  out  12  pixels to fetch; constant H_ACT
req_ready  in  1  reader accepts request
line_done  in  1  one-cycle pulse: requested line fully written to line FIFO
frame_start  out  1  one-cycle pulse on v_sync rising edge
underflow  out  1  one-cycle pulse: active line began with no delivered line
busy  out  1  request outstanding or flush in progress

Behaviour:
- Reset (async, rst_n=0): all outputs 0. State IDLE. Counters req_line, dlv_line and cons_line = 0. Shadow base = 0.
- v_sync and pixel_de are registered once (vs_d, de_d).
  - vs_rise = v_sync & ~vs_d.
  - de_rise = pixel_de & ~de_d.
  - de_fall = ~pixel_de & de_d.
- frame_start = vs_rise, registered: it appears one cycle after the first v_sync-high cycle is sampled.
- FSM states: IDLE, ARM, REQ, WAIT, FLUSH.
  - IDLE: wait for vs_rise, then go to ARM.
  - ARM (1 cycle):
    - shadow_base <= frame_base; req_addr <= frame_base.
    - Clear all three counters.
    - Go to REQ.
  - REQ: req_valid = 1 when (req_line - cons_line) < PREFETCH_LINES and req_line < V_ACT; otherwise 0.
    - On req_valid & req_ready: req_line++, go to WAIT.
    - req_valid and req_addr stay stable until accepted.
  - WAIT: req_valid = 0. On line_done:
    - dlv_line++.
    - req_addr += LINE_STRIDE (ADDR_W modulo wrap).
    - Go to REQ.
  - At most one request is outstanding at any time.
- Consumption:
  - de_fall: cons_line++, saturating at req_line.
  - de_rise with dlv_line == cons_line: underflow pulses 1 cycle; the counters are not altered.
- Frame restart: vs_rise in REQ or ARM goes to ARM.
  - vs_rise in WAIT goes to FLUSH. FLUSH holds req_valid = 0 until line_done (which is discarded), then goes to ARM.
  - vs_rise during FLUSH is ignored.
- The frame is complete when req_line == V_ACT. After that, REQ idles with req_valid = 0 until vs_rise.
- line_done outside WAIT/FLUSH is ignored.
- busy = 1 in WAIT or FLUSH.
- Counter widths: 11 bits. Subtraction is unsigned; req_line >= cons_line always holds.
- rst_n asserted mid-transfer: immediate return to the reset state. The reader must be reset by the same rst_n.

Decomposition:
- vga_pkg holds:
  - timing constants (H_ACT, V_ACT, H_SYNC, H_BP, V_SYNC, V_BP totals);
  - the FSM state encoding (localparams IDLE=0 .. FLUSH=4);
  - the LINE_STRIDE default.
- One sub-module: vga_edge_det, a registered rising/falling detector, instantiated for v_sync and pixel_de.

Test Plan (all tests override H_ACT=8, V_ACT=4, LINE_STRIDE=32, PREFETCH_LINES=2, frame_base=0x1000):
- Normal frame, req_ready=1, line_done 3 cycles after accept -> frame_start pulse; exactly 2 requests (0x1000, 0x1020) before first pixel_de; 4 requests total; no underflow.
- req_ready held 0 for 5 cycles -> req_valid stays 1 with req_addr=0x1000 stable; accepted on the first ready cycle.
- Prefetch limit: line_done prompt, pixel_de absent -> req_valid drops after 2 requests. After the first de_fall, the 3rd request is issued at 0x1040.
- line_done withheld past pixel_de rise of line 0 -> underflow pulses exactly once; later lines normal after delivery.
- vs_rise while in WAIT, new frame_base=0x8000 -> FLUSH; busy=1 until line_done, then ARM; the next request is at 0x8000.
- rst_n pulsed low mid-REQ -> req_valid=0, busy=0 immediately; nothing requested until the next vs_rise.
